// File: rtl/coord_pkg.sv
// Shared definitions for the coordinate collection and emission paths:
// default geometry of the coordinate memory and the emitter state encoding.
package coord_pkg;

    // Width of a single x or y coordinate.
    localparam int DEFAULT_COORD_W = 256;

    // Coordinate memory address width; the memory holds 2**ADDR_W pairs.
    localparam int DEFAULT_ADDR_W  = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        WAIT_MEM = 3'd2,
        PRESENT  = 3'd3,
        FINISH   = 3'd4
    } emitter_state_t;

endpackage : coord_pkg

// File: rtl/coordinate_emitter.sv
// Reads stored (x,y) pairs back from the coordinate memory in address order
// and streams them to the pathfinding core over a valid/ready handshake.
// Each pair costs three cycles: issue the read, capture the data, present it.
module coordinate_emitter
    import coord_pkg::*;
#(
    parameter int COORD_W = DEFAULT_COORD_W,
    parameter int ADDR_W  = DEFAULT_ADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W:0]    coord_count,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [COORD_W-1:0] mem_rd_x,
    input  logic [COORD_W-1:0] mem_rd_y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    // Full memory depth expressed in the (ADDR_W+1)-bit count domain, so a
    // count equal to DEPTH is representable without overflow.
    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_CNT   = {{ADDR_W{1'b0}}, 1'b1};

    emitter_state_t     state_q, state_d;
    logic [ADDR_W:0]    index_q, index_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic [COORD_W-1:0] out_x_q, out_x_d;
    logic [COORD_W-1:0] out_y_q, out_y_d;
    logic               out_last_q, out_last_d;

    logic [ADDR_W:0]    count_clamped;

    // Requests beyond the memory depth are limited to the whole memory.
    assign count_clamped = (coord_count > DEPTH_CNT) ? DEPTH_CNT : coord_count;

    // Next-state, index and holding-register update.
    always_comb begin
        // NOTE: every variable gets a default here so no path leaves it
        // unassigned; an unassigned path would infer a latch.
        state_d    = state_q;
        index_d    = index_q;
        count_d    = count_q;
        out_x_d    = out_x_q;
        out_y_d    = out_y_q;
        out_last_d = out_last_q;

        unique case (state_q)
            IDLE, FINISH: begin
                // A new run always restarts from address 0; start is only
                // seen here, so a start while busy has no effect.
                if (start) begin
                    count_d = count_clamped;
                    index_d = '0;
                    state_d = (count_clamped == '0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                state_d = WAIT_MEM;
            end
            WAIT_MEM: begin
                // Read data is valid exactly one cycle after the strobe.
                out_x_d    = mem_rd_x;
                out_y_d    = mem_rd_y;
                out_last_d = (index_q == (count_q - ONE_CNT));
                state_d    = PRESENT;
            end
            PRESENT: begin
                // Without a transfer the holding registers stay untouched,
                // which keeps out_x/out_y/out_last bit-stable under stall.
                if (out_ready) begin
                    if (out_last_q) begin
                        state_d = FINISH;
                    end else begin
                        index_d = index_q + ONE_CNT;
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and output holding registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            index_q    <= '0;
            count_q    <= '0;
            // NOTE: the wide data holders are ordinary flops, not a memory
            // array, so resetting them is cheap and makes the outputs
            // deterministic after reset.
            out_x_q    <= '0;
            out_y_q    <= '0;
            out_last_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from
            // the same pre-edge values regardless of statement order.
            state_q    <= state_d;
            index_q    <= index_d;
            count_q    <= count_d;
            out_x_q    <= out_x_d;
            out_y_q    <= out_y_d;
            out_last_q <= out_last_d;
        end
    end

    // Outputs decode directly from the registered state.
    assign mem_rd_en = (state_q == FETCH);
    assign mem_addr  = (state_q == FETCH) ? index_q[ADDR_W-1:0] : '0;
    assign out_valid = (state_q == PRESENT);
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == FETCH) || (state_q == WAIT_MEM) || (state_q == PRESENT);
    assign done      = (state_q == FINISH);

endmodule : coordinate_emitter
